// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - packet type and constants shared by the fetch/decode queue
package rv_fetch_pkg;

  localparam int          FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc_plus4;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - elastic fetch-to-decode packet queue with flush
// Optional same-cycle empty-queue bypass enabled by defining FDQ_BYPASS_EN.
module fetch_decode_queue
  import rv_fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic [XLEN-1:0]          in_pc_plus4,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc_plus4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_pkt_t      mem_q [DEPTH];
  fetch_pkt_t      mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  fetch_pkt_t      in_pkt;
  fetch_pkt_t      head_pkt;
  logic            empty;
  logic            full;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            mem_wr;
  logic            mem_rd;

  assign in_pkt = '{pc: in_pc, instr: in_instr, pc_plus4: in_pc_plus4};
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));

`ifdef FDQ_BYPASS_EN
  assign bypass = !flush && empty && in_valid;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready  = !flush && !full;
  assign out_valid = !flush && (!empty || bypass);
  assign head_pkt  = bypass ? in_pkt : mem_q[rd_ptr_q];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  // A bypassed packet consumed this cycle never touches storage or pointers.
  assign mem_wr = push && !(bypass && out_ready);
  assign mem_rd = pop && !bypass;

  assign out_pc       = out_valid ? head_pkt.pc       : '0;
  assign out_instr    = out_valid ? head_pkt.instr    : XLEN'(NOP_INSTR);
  assign out_pc_plus4 = out_valid ? head_pkt.pc_plus4 : '0;
  assign count        = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (mem_wr) begin
        mem_d[wr_ptr_q] = in_pkt;
        wr_ptr_d        = PW'(wr_ptr_q + 1'b1);
      end
      if (mem_rd) begin
        rd_ptr_d = PW'(rd_ptr_q + 1'b1);
      end
      case ({mem_wr, mem_rd})
        2'b10:   count_d = CW'(count_q + 1'b1);
        2'b01:   count_d = CW'(count_q - 1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
